// File: rtl/reset_sequencer.sv
// reset_sequencer: turns the raw board reset into an ordered set of per-subsystem
// active-low resets. Stage 0 is released first, each later stage follows after a
// minimum dwell and (optionally) a synchronized readiness ack from the previous stage.
//
// Ports:
//   CLK          design clock
//   RESET        board reset, asynchronous assert, active-low
//   ext_rst_req  synchronous level request to re-run the whole sequence
//   stage_ack    per-stage ready levels, asynchronous to CLK
//   rst_n        sequenced active-low resets, bit 0 released first
//   seq_done     all stages released
//   busy         sequence in progress
//   error        sticky ack-timeout flag (cleared only by RESET)
//
// Macro RSTSEQ_ACK_EN: when defined, stage_ack is synchronized and gates each stage,
// and a missing ack times out, sets error and restarts the sequence. When undefined,
// stage_ack is ignored, stages advance on STAGE_DELAY alone and error stays 0.
module reset_sequencer #(
   parameter int NSTAGES     = 3,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_DELAY = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               ext_rst_req,
   input  logic [NSTAGES-1:0] stage_ack,
   output logic [NSTAGES-1:0] rst_n,
   output logic               seq_done,
   output logic               busy,
   output logic               error
);

   localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam int KW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [KW-1:0] K_LAST       = KW'(NSTAGES - 1);

   typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE} state_t;

   // Reset release synchronizer: asserts with RESET, releases SYNC_STAGES edges later.
   logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
   logic                   rst_sync;

   always_comb rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_sync = rst_sync_q[SYNC_STAGES-1];

   logic [NSTAGES-1:0] ack_sync;
   logic               ack_cur;
   logic               timeout_hit;

   state_t             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NSTAGES-1:0] rst_n_q, rst_n_d;
   logic               seq_done_q, seq_done_d;
   logic               busy_q, busy_d;
   logic               error_q, error_d;

`ifdef RSTSEQ_ACK_EN
   // Per-bit ack synchronizer; the FSM only ever looks at the last flop.
   logic [NSTAGES-1:0] ack_sync_q [SYNC_STAGES];
   logic [NSTAGES-1:0] ack_sync_d [SYNC_STAGES];

   always_comb begin
      ack_sync_d[0] = stage_ack;
      for (int i = 1; i < SYNC_STAGES; i++) ack_sync_d[i] = ack_sync_q[i-1];
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) ack_sync_q[i] <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) ack_sync_q[i] <= ack_sync_d[i];
      end
   end

   assign ack_sync    = ack_sync_q[SYNC_STAGES-1];
   assign ack_cur     = ack_sync[k_q];
   // ACK_TIMEOUT > STAGE_DELAY, so a present ack always advances before this fires.
   assign timeout_hit = (cnt_q == TIMEOUT_LAST) && !ack_cur;
`else
   logic unused_stage_ack;
   assign unused_stage_ack = ^stage_ack;
   assign ack_sync         = '1;
   assign ack_cur          = ack_sync[k_q];
   assign timeout_hit      = 1'b0;
`endif

   // State register (all outputs are registered here as well).
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_HOLD;
         k_q        <= '0;
         cnt_q      <= '0;
         rst_n_q    <= '0;
         seq_done_q <= 1'b0;
         busy_q     <= 1'b1;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         rst_n_q    <= rst_n_d;
         seq_done_q <= seq_done_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      rst_n_d = rst_n_q;
      error_d = error_q;

      // A restart request wins over any advance or timeout in the same cycle, and
      // keeps the hold counter parked at 0 for as long as it is held.
      if (!rst_sync || ext_rst_req) begin
         state_d = S_HOLD;
         k_d     = '0;
         cnt_d   = '0;
         rst_n_d = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_n_d = NSTAGES'(1);
                  k_d     = '0;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_WAIT: begin
               if (cnt_q >= DELAY_LAST && ack_cur) begin
                  cnt_d = '0;
                  if (k_q == K_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     k_d     = k_q + KW'(1);
                     rst_n_d = rst_n_q | (NSTAGES'(1) << k_d);
                  end
               end else if (timeout_hit) begin
                  error_d = 1'b1;
                  rst_n_d = '0;
                  k_d     = '0;
                  cnt_d   = '0;
                  state_d = S_HOLD;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DONE: ;
            default: state_d = S_HOLD;
         endcase
      end

      seq_done_d = (state_d == S_DONE);
      busy_d     = (state_d != S_DONE);
   end

   // Output logic.
   always_comb begin
      rst_n    = rst_n_q;
      seq_done = seq_done_q;
      busy     = busy_q;
      error    = error_q;
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output transitions (edge number and
// value of {rst_n, seq_done, busy, error}) are queued when a scenario is set up, and
// each observed output change is popped and compared against the head of the queue.
module tb_reset_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ext_rst_req = 1'b0;
   logic [2:0] stage_ack = 3'b000;
   logic [2:0] rst_n;
   logic       seq_done;
   logic       busy;
   logic       error;

   reset_sequencer #(
      .NSTAGES(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGE_DELAY(8), .ACK_TIMEOUT(64)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ext_rst_req(ext_rst_req), .stage_ack(stage_ack),
      .rst_n(rst_n), .seq_done(seq_done), .busy(busy), .error(error)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         edge_n;
      logic [5:0] val;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         edge_n = 0;
   logic [5:0] prev;

   // {rst_n[2:0], seq_done, busy, error}
   localparam logic [5:0] V_RST  = 6'b000_010;
   localparam logic [5:0] V_S0   = 6'b001_010;
   localparam logic [5:0] V_S1   = 6'b011_010;
   localparam logic [5:0] V_S2   = 6'b111_010;
   localparam logic [5:0] V_DONE = 6'b111_100;
   localparam logic [5:0] V_TO   = 6'b000_011;
   localparam logic [5:0] V_S0E  = 6'b001_011;
   localparam logic [5:0] V_S1E  = 6'b011_011;

   task automatic push_exp(input int e, input logic [5:0] v);
      exp_t x;
      x.edge_n = e;
      x.val    = v;
      exp_q.push_back(x);
   endtask

   task automatic tick(output logic [5:0] obs);
      @(posedge CLK);
      #1;
      edge_n++;
      obs = {rst_n, seq_done, busy, error};
   endtask

   task automatic assert_reset();
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RESET  = 1'b1;
      edge_n = 0;
      prev   = {rst_n, seq_done, busy, error};
   endtask

   task automatic test_power_on();
      logic [5:0] obs;
      exp_t       e;
      ext_rst_req = 1'b0;
`ifdef RSTSEQ_ACK_EN
      stage_ack = 3'b111;
`else
      stage_ack = 3'b000;
`endif
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      obs = {rst_n, seq_done, busy, error};
      checks++;
      if (obs !== V_RST) begin
         errors++;
         $display("FAIL power_on_reset_values got %b want %b", obs, V_RST);
      end
      repeat (2) @(negedge CLK);
      push_exp(18, V_S0);
      push_exp(26, V_S1);
      push_exp(34, V_S2);
      push_exp(42, V_DONE);
      release_reset();
      for (int i = 0; i < 50; i++) begin
         tick(obs);
         if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL power_on unexpected change edge %0d got %b", edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != edge_n || e.val !== obs) begin
                  errors++;
                  $display("FAIL power_on edge %0d got %b want edge %0d value %b",
                           edge_n, obs, e.edge_n, e.val);
               end
            end
         end
         prev = obs;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL power_on missing %0d transitions, next at edge %0d",
                  exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask

`ifdef RSTSEQ_ACK_EN
   task automatic test_ack_late();
      logic [5:0] obs;
      exp_t       e;
      stage_ack = 3'b101;
      assert_reset();
      push_exp(18, V_S0);
      push_exp(26, V_S1);
      push_exp(42, V_S2);
      push_exp(50, V_DONE);
      release_reset();
      for (int i = 0; i < 55; i++) begin
         tick(obs);
         if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ack_late unexpected change edge %0d got %b", edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != edge_n || e.val !== obs) begin
                  errors++;
                  $display("FAIL ack_late edge %0d got %b want edge %0d value %b",
                           edge_n, obs, e.edge_n, e.val);
               end
            end
         end
         prev = obs;
         // First sync flop captures the ack at edge 40.
         if (edge_n == 39) stage_ack = 3'b111;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ack_late missing %0d transitions, next at edge %0d",
                  exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask

   task automatic test_timeout();
      logic [5:0] obs;
      exp_t       e;
      stage_ack = 3'b101;
      assert_reset();
      push_exp(18,  V_S0);
      push_exp(26,  V_S1);
      push_exp(90,  V_TO);
      push_exp(106, V_S0E);
      push_exp(114, V_S1E);
      release_reset();
      for (int i = 0; i < 120; i++) begin
         tick(obs);
         if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL timeout unexpected change edge %0d got %b", edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != edge_n || e.val !== obs) begin
                  errors++;
                  $display("FAIL timeout edge %0d got %b want edge %0d value %b",
                           edge_n, obs, e.edge_n, e.val);
               end
            end
         end
         prev = obs;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout missing %0d transitions, next at edge %0d",
                  exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask
`endif

   // ext_rst_req single-cycle pulse (sampled at edge 60) or a 10-cycle hold
   // (sampled at edges 60..69); the hold counter only starts once it drops.
   task automatic test_ext_req(input int hold_len);
      logic [5:0] obs;
      exp_t       e;
      int         rel;
      int         n_edges;
`ifdef RSTSEQ_ACK_EN
      stage_ack = 3'b111;
`else
      stage_ack = 3'b000;
`endif
      assert_reset();
      rel     = 60 + hold_len + 15;
      n_edges = (hold_len == 1) ? 105 : 95;
      push_exp(18, V_S0);
      push_exp(26, V_S1);
      push_exp(34, V_S2);
      push_exp(42, V_DONE);
      push_exp(60, V_RST);
      push_exp(rel,      V_S0);
      push_exp(rel + 8,  V_S1);
      if (hold_len == 1) begin
         push_exp(rel + 16, V_S2);
         push_exp(rel + 24, V_DONE);
      end
      release_reset();
      for (int i = 0; i < n_edges; i++) begin
         tick(obs);
         if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ext_req(%0d) unexpected change edge %0d got %b",
                        hold_len, edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != edge_n || e.val !== obs) begin
                  errors++;
                  $display("FAIL ext_req(%0d) edge %0d got %b want edge %0d value %b",
                           hold_len, edge_n, obs, e.edge_n, e.val);
               end
            end
         end
         prev = obs;
         if (edge_n == 59)            ext_rst_req = 1'b1;
         if (edge_n == 59 + hold_len) ext_rst_req = 1'b0;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ext_req(%0d) missing %0d transitions, next at edge %0d",
                  hold_len, exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask

   // Entered mid-sequence (rst_n[1] already up); RESET must clear outputs with no edge.
   task automatic test_midseq_reset();
      logic [5:0] obs;
      exp_t       e;
      @(negedge CLK);
      #2;
      RESET = 1'b0;
      #1;
      obs = {rst_n, seq_done, busy, error};
      checks++;
      if (obs !== V_RST) begin
         errors++;
         $display("FAIL midseq_async_reset got %b want %b", obs, V_RST);
      end
      stage_ack = 3'b111;
      repeat (2) @(negedge CLK);
`ifdef RSTSEQ_ACK_EN
      push_exp(18, V_S0);
      push_exp(26, V_S1);
      push_exp(34, V_S2);
      push_exp(42, V_DONE);
`else
      stage_ack = 3'b010;
      push_exp(18, V_S0);
      push_exp(26, V_S1);
      push_exp(34, V_S2);
      push_exp(42, V_DONE);
`endif
      release_reset();
      for (int i = 0; i < 50; i++) begin
         tick(obs);
         if (obs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL midseq unexpected change edge %0d got %b", edge_n, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != edge_n || e.val !== obs) begin
                  errors++;
                  $display("FAIL midseq edge %0d got %b want edge %0d value %b",
                           edge_n, obs, e.edge_n, e.val);
               end
            end
         end
         prev = obs;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL midseq missing %0d transitions, next at edge %0d",
                  exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask

   initial begin
      test_power_on();
`ifdef RSTSEQ_ACK_EN
      test_ack_late();
`endif
      test_ext_req(1);
      test_ext_req(10);
`ifdef RSTSEQ_ACK_EN
      test_timeout();
`endif
      test_midseq_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
